// File: rtl/snax_csr_router_pkg.sv
// rtl/snax_csr_router_pkg.sv - shared types and constants for the CSR router
//
// Purpose: helpers for sizing the port-ID type, plus the constant response
// that is returned for reads to unmapped addresses.
// Ports: none (package).
package snax_csr_router_pkg;

  // A port ID names one of NumPorts targets, or the value NumPorts for
  // "unmapped". This gives the bit width needed for that range.
  function automatic int unsigned port_id_width(input int unsigned num_ports);
    return (num_ports < 1) ? 1 : $clog2(num_ports + 1);
  endfunction

  // Response returned for an unmapped read: zero data with the error flag set.
  localparam logic [63:0] DecodeErrData = 64'h0;
  localparam logic        DecodeErrFlag = 1'b1;

endpackage

// File: rtl/snax_csr_id_fifo.sv
// rtl/snax_csr_id_fifo.sv - in-order FIFO of target IDs for outstanding reads
//
// Purpose: records, in request order, which port owes a read response.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, push_id_i enqueue an ID (ignored while full)
//   pop_i             dequeue the head (ignored while empty)
//   head_o            ID at the head of the queue
//   full_o, empty_o   occupancy flags
module snax_csr_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_id_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id_i;
  end

endmodule

// File: rtl/snax_csr_router.sv
// rtl/snax_csr_router.sv - address-decoding CSR router with in-order read responses
//
// Purpose: routes one CSR request stream to NumPorts accelerator ports by
// base address and returns read responses in request order.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   csr_req_*                upstream request (addr, data, wen, valid/ready)
//   csr_rsp_*                upstream response (data, err, valid/ready)
//   acc_csr_req_*            per-port requests (offset addr, data, wen, valid/ready)
//   acc_csr_rsp_*            per-port responses (data, valid/ready)
module snax_csr_router
  import snax_csr_router_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned RegAddrWidth   = 32,
  parameter int unsigned RegDataWidth   = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [NumPorts-1:0][RegAddrWidth-1:0] PortBase =
    {RegAddrWidth'(8), RegAddrWidth'(0)}
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [RegAddrWidth-1:0] csr_req_addr_i,
  input  logic [RegDataWidth-1:0] csr_req_data_i,
  input  logic                    csr_req_wen_i,
  input  logic                    csr_req_valid_i,
  output logic                    csr_req_ready_o,
  output logic [RegDataWidth-1:0] csr_rsp_data_o,
  output logic                    csr_rsp_err_o,
  output logic                    csr_rsp_valid_o,
  input  logic                    csr_rsp_ready_i,
  output logic [RegAddrWidth-1:0] acc_csr_req_addr_o  [NumPorts],
  output logic [RegDataWidth-1:0] acc_csr_req_data_o  [NumPorts],
  output logic [NumPorts-1:0]     acc_csr_req_wen_o,
  output logic [NumPorts-1:0]     acc_csr_req_valid_o,
  input  logic [NumPorts-1:0]     acc_csr_req_ready_i,
  input  logic [RegDataWidth-1:0] acc_csr_rsp_data_i  [NumPorts],
  input  logic [NumPorts-1:0]     acc_csr_rsp_valid_i,
  output logic [NumPorts-1:0]     acc_csr_rsp_ready_o
);

  localparam int unsigned IdW = port_id_width(NumPorts);
  typedef logic [IdW-1:0] port_id_t;

  localparam port_id_t UnmappedId = port_id_t'(NumPorts);

  port_id_t sel_id;
  port_id_t head_id;
  logic     mapped;
  logic     fifo_full;
  logic     fifo_empty;
  logic     read_blocked;
  logic     push;
  logic     pop;

  // Bases are ascending, so the last base not above the address wins.
  always_comb begin
    mapped = 1'b0;
    sel_id = UnmappedId;
    for (int i = 0; i < NumPorts; i++) begin
      if (csr_req_addr_i >= PortBase[i]) begin
        mapped = 1'b1;
        sel_id = port_id_t'(i);
      end
    end
  end

  // Reads need a free ID slot; writes never produce a response.
  assign read_blocked = !csr_req_wen_i && fifo_full;

  always_comb begin
    acc_csr_req_wen_o   = '0;
    acc_csr_req_valid_o = '0;
    csr_req_ready_o     = !mapped;
    for (int i = 0; i < NumPorts; i++) begin
      acc_csr_req_addr_o[i] = '0;
      acc_csr_req_data_o[i] = '0;
      if (mapped && (sel_id == port_id_t'(i))) begin
        acc_csr_req_addr_o[i]  = csr_req_addr_i - PortBase[i];
        acc_csr_req_data_o[i]  = csr_req_data_i;
        acc_csr_req_wen_o[i]   = csr_req_wen_i;
        acc_csr_req_valid_o[i] = csr_req_valid_i && !read_blocked;
        csr_req_ready_o        = acc_csr_req_ready_i[i];
      end
    end
    if (read_blocked) csr_req_ready_o = 1'b0;
  end

  assign push = csr_req_valid_i && csr_req_ready_o && !csr_req_wen_i;
  assign pop  = csr_rsp_valid_o && csr_rsp_ready_i;

  snax_csr_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) i_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .push_id_i (sel_id),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Only the port owing the oldest response may hand it over; an unmapped
  // head answers on its own with the decode-error response.
  always_comb begin
    csr_rsp_valid_o     = 1'b0;
    csr_rsp_data_o      = '0;
    csr_rsp_err_o       = 1'b0;
    acc_csr_rsp_ready_o = '0;
    if (!fifo_empty) begin
      if (head_id == UnmappedId) begin
        csr_rsp_valid_o = 1'b1;
        csr_rsp_data_o  = RegDataWidth'(DecodeErrData);
        csr_rsp_err_o   = DecodeErrFlag;
      end else begin
        for (int i = 0; i < NumPorts; i++) begin
          if (head_id == port_id_t'(i)) begin
            csr_rsp_valid_o        = acc_csr_rsp_valid_i[i];
            csr_rsp_data_o         = acc_csr_rsp_data_i[i];
            acc_csr_rsp_ready_o[i] = csr_rsp_ready_i;
          end
        end
      end
    end
  end

endmodule
